lsu_mem_port: RTL and testbench

- Parametrised successor to the single-cycle memory stage: a load/store unit between the MEM pipeline stage and a variable-latency data memory bus.
- Accepts one load or store per request handshake and converts the size code into byte-lane masks and bus-aligned addresses.
- Sign/zero-extends load data and detects misaligned accesses, invalid sizes and bus timeouts.
- Replaces the combinational read/write path so that multi-cycle memory (cache or AXI bridge) can sit behind it.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_load_align.sv | 43 ++++
 rtl/lsu_mem_port.sv | 177 +++++++++++++++++
 tb/tb_lsu_mem_port.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared size codes, FSM state type and size decode helpers for the load/store unit.
// Used by the memory port and the load alignment datapath.
package lsu_pkg;

   localparam logic [3:0] SZ_B = 4'b0001;
   localparam logic [3:0] SZ_H = 4'b0010;
   localparam logic [3:0] SZ_W = 4'b0100;
   localparam logic [3:0] SZ_D = 4'b1000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_RESP
   } lsu_state_e;

   // Returns 0 for any code that is not exactly one-hot.
   function automatic logic [3:0] size_to_bytes(input logic [3:0] size);
      case (size)
         SZ_B:    return 4'd1;
         SZ_H:    return 4'd2;
         SZ_W:    return 4'd4;
         SZ_D:    return 4'd8;
         default: return 4'd0;
      endcase
   endfunction

   function automatic logic [7:0] size_to_mask(input logic [3:0] size);
      case (size)
         SZ_B:    return 8'h01;
         SZ_H:    return 8'h03;
         SZ_W:    return 8'h0F;
         SZ_D:    return 8'hFF;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load alignment: shift the bus word down to the access offset, truncate to the size and extend.
// Purely combinational; no flow control.
module lsu_load_align
   import lsu_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int OFF_W = $clog2(XLEN / 8)
) (
   input  logic [XLEN-1:0]  word,
   input  logic [OFF_W-1:0] offset,
   input  logic [3:0]       size,
   input  logic             is_unsigned,
   output logic [XLEN-1:0]  data
);

   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] keep;
   logic            sign_bit;

   // A keep-mask avoids zero-width replications when the size equals XLEN.
   always_comb begin
      shifted  = word >> {offset, 3'b000};
      keep     = '1;
      sign_bit = 1'b0;
      case (size)
         SZ_B: begin
            keep     = XLEN'(8'hFF);
            sign_bit = shifted[7];
         end
         SZ_H: begin
            keep     = XLEN'(16'hFFFF);
            sign_bit = shifted[15];
         end
         SZ_W: begin
            keep     = XLEN'(32'hFFFF_FFFF);
            sign_bit = shifted[31];
         end
         default: ;
      endcase
      data = (shifted & keep) | ((sign_bit && !is_unsigned) ? ~keep : '0);
   end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit between the MEM stage and a variable-latency bus; one access outstanding.
// Best case 3 cycles accept-to-response (1 for errors); stalls on bus_req_ready and resp_ready.
module lsu_mem_port
   import lsu_pkg::*;
#(
   parameter int XLEN           = 64,
   parameter int ADDR_W         = 64,
   parameter int TIMEOUT        = 255,
   parameter int ALLOW_MISALIGN = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_is_store,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   input  logic [3:0]        req_size,
   input  logic              req_unsigned,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_err,
   output logic              bus_req_valid,
   input  logic              bus_req_ready,
   output logic              bus_req_we,
   output logic [ADDR_W-1:0] bus_req_addr,
   output logic [XLEN-1:0]   bus_req_wdata,
   output logic [XLEN/8-1:0] bus_req_wmask,
   input  logic              bus_resp_valid,
   input  logic [XLEN-1:0]   bus_resp_rdata
);

   localparam int NB       = XLEN / 8;
   localparam int OFF_W    = $clog2(NB);
   localparam int CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam int TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

   lsu_state_e        state_q, state_d;
   logic              is_store_q, is_store_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [3:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic              err_q, err_d;
   logic [XLEN-1:0]   word_q, word_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [OFF_W-1:0]  off_in;
   logic [3:0]        bytes_in;
   logic              size_bad, align_bad, cross_bad;

   always_comb begin
      state_d    = state_q;
      is_store_d = is_store_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      size_d     = size_q;
      uns_d      = uns_q;
      err_d      = err_q;
      word_d     = word_q;
      cnt_d      = cnt_q;

      off_in    = req_addr[OFF_W-1:0];
      bytes_in  = size_to_bytes(req_size);
      size_bad  = (bytes_in == 4'd0) || (bytes_in > 4'(NB));
      align_bad = (ALLOW_MISALIGN == 0) &&
                  ((4'(off_in) & (bytes_in - 4'd1)) != 4'd0);
      // Accesses that spill into the next bus word can never be issued as one beat.
      cross_bad = (5'(off_in) + 5'(bytes_in)) > 5'(NB);

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               is_store_d = req_is_store;
               addr_d     = req_addr;
               wdata_d    = req_wdata;
               size_d     = req_size;
               uns_d      = req_unsigned;
               word_d     = '0;
               if (size_bad || align_bad || cross_bad) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  err_d   = 1'b0;
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (bus_req_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A response arriving on the expiry cycle takes priority over the timeout.
            if (bus_resp_valid) begin
               word_d  = bus_resp_rdata;
               err_d   = 1'b0;
               cnt_d   = '0;
               state_d = ST_RESP;
            end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
               word_d  = '0;
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = ST_RESP;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         is_store_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         size_q     <= '0;
         uns_q      <= 1'b0;
         err_q      <= 1'b0;
         word_q     <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         size_q     <= size_d;
         uns_q      <= uns_d;
         err_q      <= err_d;
         word_q     <= word_d;
         cnt_q      <= cnt_d;
      end
   end

   logic              st_req, st_resp, st_wr;
   logic [OFF_W-1:0]  off_q;
   logic [NB-1:0]     mask_base;
   logic [XLEN-1:0]   load_data;

   assign st_req    = (state_q == ST_REQ);
   assign st_resp   = (state_q == ST_RESP);
   assign st_wr     = st_req && is_store_q;
   assign off_q     = addr_q[OFF_W-1:0];
   assign mask_base = NB'(size_to_mask(size_q));

   lsu_load_align #(
      .XLEN (XLEN),
      .OFF_W(OFF_W)
   ) u_load_align (
      .word       (word_q),
      .offset     (off_q),
      .size       (size_q),
      .is_unsigned(uns_q),
      .data       (load_data)
   );

   assign req_ready     = (state_q == ST_IDLE);
   assign bus_req_valid = st_req;
   assign bus_req_we    = st_wr;
   assign bus_req_addr  = st_req ? {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)} : '0;
   assign bus_req_wmask = st_wr ? (mask_base << off_q) : '0;
   assign bus_req_wdata = st_wr ? (wdata_q << {off_q, 3'b000}) : '0;
   assign resp_valid    = st_resp;
   assign resp_err      = st_resp && err_q;
   assign resp_rdata    = (st_resp && !is_store_q && !err_q) ? load_data : '0;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: one strict-alignment instance and one misalign-tolerant instance.
module tb_lsu_mem_port;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid, req_valid_m;
   logic        req_is_store;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [3:0]  req_size;
   logic        req_unsigned;
   logic        resp_ready;
   logic        bus_req_ready;
   logic        bus_resp_valid;
   logic [63:0] bus_resp_rdata;

   logic        req_ready, resp_valid, resp_err, bus_req_valid, bus_req_we;
   logic [63:0] resp_rdata, bus_req_addr, bus_req_wdata;
   logic [7:0]  bus_req_wmask;

   logic        req_ready_m, resp_valid_m, resp_err_m, bus_req_valid_m, bus_req_we_m;
   logic [63:0] resp_rdata_m, bus_req_addr_m, bus_req_wdata_m;
   logic [7:0]  bus_req_wmask_m;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   lsu_mem_port #(.XLEN(64), .ADDR_W(64), .TIMEOUT(4), .ALLOW_MISALIGN(0)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .req_unsigned(req_unsigned),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
      .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_wmask(bus_req_wmask),
      .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata)
   );

   lsu_mem_port #(.XLEN(64), .ADDR_W(64), .TIMEOUT(4), .ALLOW_MISALIGN(1)) dut_m (
      .clock(clock), .reset(reset),
      .req_valid(req_valid_m), .req_ready(req_ready_m), .req_is_store(req_is_store),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .req_unsigned(req_unsigned),
      .resp_valid(resp_valid_m), .resp_ready(resp_ready), .resp_rdata(resp_rdata_m),
      .resp_err(resp_err_m),
      .bus_req_valid(bus_req_valid_m), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we_m),
      .bus_req_addr(bus_req_addr_m), .bus_req_wdata(bus_req_wdata_m),
      .bus_req_wmask(bus_req_wmask_m),
      .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_valid_m = 1'b0; req_is_store = 1'b0;
      req_addr = '0; req_wdata = '0; req_size = '0; req_unsigned = 1'b0;
      resp_ready = 1'b0; bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_rdata = '0;
      tick(); tick();
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_bus_req_valid", bus_req_valid, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_wmask", bus_req_wmask, 0);
      reset = 1'b0;

      // Signed byte load, best-case bus, then response backpressure.
      req_valid = 1; req_is_store = 0; req_addr = 64'h8000_0003; req_size = 4'b0001; req_unsigned = 0;
      tick();
      req_valid = 0; req_addr = '0;
      chk("lb_bus_vld", bus_req_valid, 1);
      chk("lb_bus_addr", bus_req_addr, 64'h8000_0000);
      chk("lb_we", bus_req_we, 0);
      chk("lb_wmask", bus_req_wmask, 0);
      chk("lb_req_ready", req_ready, 0);
      chk("lb_resp_vld_early", resp_valid, 0);
      bus_req_ready = 1;
      tick();
      bus_req_ready = 0;
      chk("lb_wait_bus_vld", bus_req_valid, 0);
      chk("lb_wait_resp_vld", resp_valid, 0);
      bus_resp_valid = 1; bus_resp_rdata = 64'h0000_0000_8000_0000;
      tick();
      bus_resp_valid = 0; bus_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      chk("lb_resp_vld", resp_valid, 1);
      chk("lb_rdata", resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
      chk("lb_err", resp_err, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("lb_hold_vld", resp_valid, 1);
         chk("lb_hold_rdata", resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
         chk("lb_hold_req_ready", req_ready, 0);
      end
      resp_ready = 1;
      tick();
      resp_ready = 0;
      chk("lb_done_req_ready", req_ready, 1);
      chk("lb_done_resp_vld", resp_valid, 0);

      // Store half with bus request backpressure.
      req_valid = 1; req_is_store = 1; req_addr = 64'h8000_0006; req_wdata = 64'hABCD; req_size = 4'b0010;
      tick();
      req_valid = 0; req_addr = '0; req_wdata = '0;
      for (int i = 0; i < 5; i++) begin
         chk("sh_bus_vld", bus_req_valid, 1);
         chk("sh_addr", bus_req_addr, 64'h8000_0000);
         chk("sh_wmask", bus_req_wmask, 8'hC0);
         chk("sh_wdata", bus_req_wdata, 64'hABCD_0000_0000_0000);
         chk("sh_we", bus_req_we, 1);
         chk("sh_req_ready", req_ready, 0);
         tick();
      end
      bus_req_ready = 1;
      tick();
      bus_req_ready = 0;
      bus_resp_valid = 1; bus_resp_rdata = 64'h1234_5678_9ABC_DEF0;
      tick();
      bus_resp_valid = 0;
      chk("sh_resp_vld", resp_valid, 1);
      chk("sh_rdata", resp_rdata, 0);
      chk("sh_err", resp_err, 0);
      resp_ready = 1;
      tick();
      resp_ready = 0;
      chk("sh_done_req_ready", req_ready, 1);

      // Misaligned word on the strict instance: immediate error, no bus traffic.
      req_valid = 1; req_is_store = 0; req_addr = 64'h8000_0002; req_size = 4'b0100;
      tick();
      req_valid = 0;
      chk("mw_bus_vld", bus_req_valid, 0);
      chk("mw_resp_vld", resp_valid, 1);
      chk("mw_err", resp_err, 1);
      chk("mw_rdata", resp_rdata, 0);
      resp_ready = 1;
      tick();
      resp_ready = 0;
      chk("mw_done_req_ready", req_ready, 1);

      // Non-one-hot size code.
      req_valid = 1; req_addr = 64'h8000_0000; req_size = 4'b0011;
      tick();
      req_valid = 0;
      chk("bs_bus_vld", bus_req_valid, 0);
      chk("bs_err", resp_err, 1);
      resp_ready = 1;
      tick();
      resp_ready = 0;

      // Word-crossing access errors even with misalignment allowed.
      req_valid_m = 1; req_addr = 64'h8000_0006; req_size = 4'b0100;
      tick();
      req_valid_m = 0;
      chk("xw_bus_vld_m", bus_req_valid_m, 0);
      chk("xw_resp_vld_m", resp_valid_m, 1);
      chk("xw_err_m", resp_err_m, 1);
      chk("xw_other_idle", resp_valid, 0);
      resp_ready = 1;
      tick();
      resp_ready = 0;

      // Misaligned word inside one bus word proceeds on the tolerant instance.
      req_valid_m = 1; req_addr = 64'h8000_0002; req_size = 4'b0100; req_unsigned = 0;
      tick();
      req_valid_m = 0;
      chk("ma_bus_vld_m", bus_req_valid_m, 1);
      chk("ma_addr_m", bus_req_addr_m, 64'h8000_0000);
      chk("ma_wmask_m", bus_req_wmask_m, 0);
      bus_req_ready = 1;
      tick();
      bus_req_ready = 0;
      bus_resp_valid = 1; bus_resp_rdata = 64'h1122_B344_5566_7788;
      tick();
      bus_resp_valid = 0;
      chk("ma_resp_vld_m", resp_valid_m, 1);
      chk("ma_rdata_m", resp_rdata_m, 64'hFFFF_FFFF_B344_5566);
      chk("ma_err_m", resp_err_m, 0);
      chk("ma_stray_ignored", resp_valid, 0);
      resp_ready = 1;
      tick();
      resp_ready = 0;

      // Unsigned half load.
      req_valid = 1; req_addr = 64'h8000_0002; req_size = 4'b0010; req_unsigned = 1;
      tick();
      req_valid = 0;
      bus_req_ready = 1;
      tick();
      bus_req_ready = 0;
      bus_resp_valid = 1; bus_resp_rdata = 64'h0000_0000_8001_0000;
      tick();
      bus_resp_valid = 0;
      chk("uh_rdata", resp_rdata, 64'h0000_0000_0000_8001);
      resp_ready = 1;
      tick();
      resp_ready = 0; req_unsigned = 0;

      // Timeout after four WAIT cycles.
      req_valid = 1; req_addr = 64'h8000_0000; req_size = 4'b1000;
      tick();
      req_valid = 0;
      bus_req_ready = 1;
      tick();
      bus_req_ready = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("to_wait_resp_vld", resp_valid, 0);
         chk("to_wait_bus_vld", bus_req_valid, 0);
      end
      tick();
      chk("to_resp_vld", resp_valid, 1);
      chk("to_err", resp_err, 1);
      chk("to_rdata", resp_rdata, 0);
      resp_ready = 1;
      tick();
      resp_ready = 0;
      chk("to_done_req_ready", req_ready, 1);

      // Response on the expiry cycle wins over the timeout.
      req_valid = 1; req_addr = 64'h8000_0008; req_size = 4'b1000;
      tick();
      req_valid = 0;
      bus_req_ready = 1;
      tick();
      bus_req_ready = 0;
      for (int i = 0; i < 3; i++) tick();
      bus_resp_valid = 1; bus_resp_rdata = 64'hFEDC_BA98_7654_3210;
      tick();
      bus_resp_valid = 0;
      chk("rc_resp_vld", resp_valid, 1);
      chk("rc_err", resp_err, 0);
      chk("rc_rdata", resp_rdata, 64'hFEDC_BA98_7654_3210);
      resp_ready = 1;
      tick();
      resp_ready = 0;

      // Reset while waiting on the bus.
      req_valid = 1; req_addr = 64'h8000_0010; req_size = 4'b1000;
      tick();
      req_valid = 0;
      bus_req_ready = 1;
      tick();
      bus_req_ready = 0;
      chk("rw_pre_req_ready", req_ready, 0);
      reset = 1;
      tick();
      reset = 0;
      chk("rw_bus_vld", bus_req_valid, 0);
      chk("rw_resp_vld", resp_valid, 0);
      chk("rw_req_ready", req_ready, 1);
      bus_resp_valid = 1; bus_resp_rdata = 64'h5555_5555_5555_5555;
      tick();
      bus_resp_valid = 0;
      chk("rw_stray_resp_vld", resp_valid, 0);
      chk("rw_stray_req_ready", req_ready, 1);
      tick();
      chk("rw_after_resp_vld", resp_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
